// File: rtl/slow_pkg.sv
// Shared types and constants for the slowdown timer: FSM states, device bit
// positions in the select/enable vectors, and the timeout field width.
package slow_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    HOLD = 2'd2
  } slow_state_e;

  localparam int NDEV = 6;
  localparam int IACK = 0;
  localparam int VIA  = 1;
  localparam int IWM  = 2;
  localparam int SCC  = 3;
  localparam int SCSI = 4;
  localparam int SND  = 5;

  localparam int TO_W = 4;

endpackage

// File: rtl/slow_prescaler.sv
// Divides CLK down to one tick per TICK_DIV cycles while running; load restarts
// the count so a fresh slow period always gets a full first unit.
module slow_prescaler #(
  parameter int TICK_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (load_i)
      pre_d = TOP;
    else if (run_i)
      pre_d = (pre_q == '0) ? TOP : pre_q - PW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  assign tick_o = run_i && (pre_q == '0);

endmodule

// File: rtl/slow_timer.sv
// Slowdown timer: a bus cycle to an enabled slow device starts (or restarts) a
// timed slow period, stretched to the end of a bus cycle still open at expiry.
module slow_timer
  import slow_pkg::*;
#(
  parameter int TICK_DIV = 16
) (
  input  logic            CLK,
  input  logic            POR,
  input  logic            BACT,
  input  logic            SelIACK,
  input  logic            SelVIA,
  input  logic            SelIWM,
  input  logic            SelSCC,
  input  logic            SelSCSI,
  input  logic            SelSnd,
  input  logic            SlowIACK,
  input  logic            SlowVIA,
  input  logic            SlowIWM,
  input  logic            SlowSCC,
  input  logic            SlowSCSI,
  input  logic            SlowSnd,
  input  logic            SlowClockGate,
  input  logic [TO_W-1:0] SlowTimeout,
  output logic            Slow,
  output logic            ClockGate
);

  logic [NDEV-1:0] sel, en;
  logic            bactr_q;
  logic            hit, tick, load;
  slow_state_e     state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            slow_q, cg_q;

  assign sel[IACK] = SelIACK;
  assign sel[VIA]  = SelVIA;
  assign sel[IWM]  = SelIWM;
  assign sel[SCC]  = SelSCC;
  assign sel[SCSI] = SelSCSI;
  assign sel[SND]  = SelSnd;

  assign en[IACK]  = SlowIACK;
  assign en[VIA]   = SlowVIA;
  assign en[IWM]   = SlowIWM;
  assign en[SCC]   = SlowSCC;
  assign en[SCSI]  = SlowSCSI;
  assign en[SND]   = SlowSnd;

  // Only the first cycle of a bus cycle can trigger.
  assign hit  = BACT && !bactr_q && |(sel & en);
  assign load = hit;

  slow_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk_i  (CLK),
    .rst_i  (POR),
    .load_i (load),
    .run_i  (state_q == SLOW),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, SLOW: begin
        if (hit) begin
          if (SlowTimeout != '0) begin
            state_d = SLOW;
            cnt_d   = SlowTimeout;
          end else begin
            state_d = HOLD;
          end
        end else if (state_q == SLOW && tick) begin
          cnt_d = cnt_q - TO_W'(1);
          if (cnt_q == TO_W'(1))
            state_d = BACT ? HOLD : IDLE;
        end
      end
      HOLD: if (!BACT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge POR) begin
    if (POR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bactr_q <= 1'b0;
      slow_q  <= 1'b0;
      cg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bactr_q <= BACT;
      slow_q  <= (state_d != IDLE);
      cg_q    <= SlowClockGate && (state_d != IDLE);
    end
  end

  assign Slow      = slow_q;
  assign ClockGate = cg_q;

endmodule

// File: tb/tb_slow_timer.sv
// Directed bench for slow_timer with TICK_DIV=4: per-cycle vector table plus a
// hand-written asynchronous reset sequence.
module tb_slow_timer;

  logic       CLK = 1'b0;
  logic       POR = 1'b1;
  logic       BACT = 1'b0;
  logic [5:0] sel = '0;
  logic [5:0] en = '0;
  logic       cg = 1'b0;
  logic [3:0] to = '0;
  logic       Slow, ClockGate;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  slow_timer #(.TICK_DIV(4)) dut (
    .CLK(CLK), .POR(POR), .BACT(BACT),
    .SelIACK(sel[0]), .SelVIA(sel[1]), .SelIWM(sel[2]),
    .SelSCC(sel[3]), .SelSCSI(sel[4]), .SelSnd(sel[5]),
    .SlowIACK(en[0]), .SlowVIA(en[1]), .SlowIWM(en[2]),
    .SlowSCC(en[3]), .SlowSCSI(en[4]), .SlowSnd(en[5]),
    .SlowClockGate(cg), .SlowTimeout(to),
    .Slow(Slow), .ClockGate(ClockGate)
  );

  typedef struct {
    logic       bact;
    logic [5:0] sel;
    logic [5:0] en;
    logic       cg;
    logic [3:0] to;
    int         n;
    logic       es;
    logic       ec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic b, input logic [5:0] s, input logic [5:0] e,
                     input logic c, input logic [3:0] t, input int n,
                     input logic es, input logic ec);
    vec_t v;
    v.bact = b; v.sel = s; v.en = e; v.cg = c; v.to = t;
    v.n = n; v.es = es; v.ec = ec;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  localparam logic [5:0] D_VIA  = 6'b000010;
  localparam logic [5:0] D_IWM  = 6'b000100;
  localparam logic [5:0] D_SCC  = 6'b001000;
  localparam logic [5:0] D_SCSI = 6'b010000;
  localparam logic [5:0] NOSCSI = 6'b101111;

  initial begin
    // Timeout 3 on VIA: 12 slow cycles, ClockGate disabled
    add(0, 0, D_VIA, 0, 3, 2, 0, 0);
    add(1, D_VIA, D_VIA, 0, 3, 4, 1, 0);
    add(0, 0, D_VIA, 0, 3, 8, 1, 0);
    add(0, 0, D_VIA, 0, 3, 2, 0, 0);
    // Timeout 0 on SCC: hold for the bus cycle, ClockGate enabled
    add(1, D_SCC, D_SCC, 1, 0, 6, 1, 1);
    add(0, 0, D_SCC, 1, 0, 2, 0, 0);
    // Timeout 2 with a 20-cycle bus cycle; ClockGate cleared mid-period
    add(1, D_SCC, D_SCC, 1, 2, 10, 1, 1);
    add(1, D_SCC, D_SCC, 0, 2, 10, 1, 0);
    add(0, 0, D_SCC, 0, 2, 2, 0, 0);
    // Retrigger at cycle 10
    add(1, D_VIA, D_VIA, 0, 3, 2, 1, 0);
    add(0, 0, D_VIA, 0, 3, 8, 1, 0);
    add(1, D_VIA, D_VIA, 0, 3, 2, 1, 0);
    add(0, 0, D_VIA, 0, 3, 10, 1, 0);
    add(0, 0, D_VIA, 0, 3, 2, 0, 0);
    // Hit on the expiry edge reloads
    add(1, D_VIA, D_VIA, 0, 3, 1, 1, 0);
    add(0, 0, D_VIA, 0, 3, 11, 1, 0);
    add(1, D_VIA, D_VIA, 0, 3, 1, 1, 0);
    add(0, 0, D_VIA, 0, 3, 11, 1, 0);
    add(0, 0, D_VIA, 0, 3, 2, 0, 0);
    // Disabled device, then a select appearing mid bus cycle
    add(1, D_SCSI, NOSCSI, 1, 3, 3, 0, 0);
    add(0, 0, NOSCSI, 1, 3, 1, 0, 0);
    add(1, 0, NOSCSI, 1, 3, 2, 0, 0);
    add(1, D_IWM, NOSCSI, 1, 3, 2, 0, 0);
    add(0, 0, NOSCSI, 1, 3, 2, 0, 0);

    // Reset state, asynchronously and after release
    #1;
    check("reset Slow", Slow, 1'b0);
    check("reset ClockGate", ClockGate, 1'b0);
    repeat (2) @(negedge CLK);
    POR = 1'b0;
    @(posedge CLK); #1;
    check("post-reset Slow", Slow, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        @(negedge CLK);
        BACT = tbl[i].bact; sel = tbl[i].sel; en = tbl[i].en;
        cg = tbl[i].cg; to = tbl[i].to;
        @(posedge CLK); #1;
        check($sformatf("row%0d cyc%0d Slow", i, c), Slow, tbl[i].es);
        check($sformatf("row%0d cyc%0d ClockGate", i, c), ClockGate, tbl[i].ec);
      end
    end

    // Reset asserted mid-period drops outputs without a clock edge
    @(negedge CLK);
    BACT = 1'b1; sel = D_VIA; en = D_VIA; cg = 1'b1; to = 4'd3;
    @(negedge CLK);
    BACT = 1'b0; sel = '0;
    repeat (3) @(posedge CLK);
    #2;
    check("por pre Slow", Slow, 1'b1);
    check("por pre ClockGate", ClockGate, 1'b1);
    POR = 1'b1;
    #1;
    check("por async Slow", Slow, 1'b0);
    check("por async ClockGate", ClockGate, 1'b0);
    @(negedge CLK);
    POR = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      check($sformatf("por after cyc%0d Slow", c), Slow, 1'b0);
    end
    @(negedge CLK);
    BACT = 1'b1; sel = D_VIA;
    @(posedge CLK); #1;
    check("por new hit Slow", Slow, 1'b1);
    check("por new hit ClockGate", ClockGate, 1'b1);
    @(negedge CLK);
    BACT = 1'b0; sel = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/slow_timer.md
Name: slow_timer

Overview:
- Consumer of the slowdown settings register: watches bus cycles to slow peripherals and holds the accelerator in slow mode for a programmed time.
- Per-device enables, the 4-bit timeout and the clock-gate flag come from the settings register; device chip-selects come from the address decoder.
- Outputs Slow, which the bus controller uses to fall back to native timing, and ClockGate, which drives the CPU clock gate.

Parameters:
- TICK_DIV, 16, CLK cycles per timeout unit; legal range 2..256.

Ports:
- CLK  in  1  system clock
- POR  in  1  asynchronous active-high reset
- BACT  in  1  bus cycle active (CPU address strobe qualified)
- SelIACK, SelVIA, SelIWM, SelSCC, SelSCSI, SelSnd  in  1 each  decoded device selects, valid while BACT=1
- SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd  in  1 each  per-device slow enables
- SlowClockGate  in  1  enables ClockGate during slow mode
- SlowTimeout  in  4  timeout, in units of TICK_DIV cycles
- Slow  out  1  slow mode active (registered)
- ClockGate  out  1  gate CPU clock (registered)

Behaviour:
- Reset (POR=1, asynchronous):
  - state=IDLE, cnt=0, pre=0, BACTr=0.
  - Slow=0, ClockGate=0.
- Sampling: BACTr <= BACT every cycle.
- hit = BACT && !BACTr && OR over devices of (Sel_x && Slow_x). A hit occurs only on the first cycle of a bus cycle.
- SlowTimeout is sampled only on a hit. Enable changes never cancel an active slow period.
- States: IDLE, SLOW, HOLD. Slow = (next state != IDLE), registered, so it rises the cycle after the hit cycle.
- IDLE:
  - On hit with SlowTimeout!=0: cnt<=SlowTimeout, pre<=TICK_DIV-1, go to SLOW.
  - On hit with SlowTimeout==0: go to HOLD.
  - Otherwise stay in IDLE.
- SLOW:
  - A hit reloads cnt<=SlowTimeout and pre<=TICK_DIV-1. A hit with SlowTimeout==0 goes to HOLD.
  - Otherwise pre decrements each cycle.
  - When pre==0: pre<=TICK_DIV-1 and cnt<=cnt-1.
  - If cnt==1 at that edge (expiry): go to HOLD if BACT=1, else IDLE.
- HOLD: stay while BACT=1; go to IDLE on the first cycle BACT=0. No hit is possible in HOLD because BACT is continuously high.
- Duration: timeout N gives Slow high for exactly N*TICK_DIV cycles, extended to the end of the bus cycle if that cycle is still active at expiry.
- ClockGate <= SlowClockGate && (next state != IDLE). It is updated live, so clearing SlowClockGate drops ClockGate one cycle later even mid-slow.
- Widths: cnt is 4 bits and never wraps (minimum 1 in SLOW). pre is clog2(TICK_DIV) bits.
- Simultaneous events: a hit on the same edge as expiry takes priority (reload). Back-to-back bus cycles (BACT low for 1 cycle, then high) each produce a hit.
- Reset mid-operation: immediate return to IDLE, outputs low on the same asynchronous assertion.

Decomposition:
- Shared package (slow_pkg):
  - state enum IDLE/SLOW/HOLD (2 bits)
  - device index constants IACK=0, VIA=1, IWM=2, SCC=3, SCSI=4, SND=5
  - timeout width constant TO_W=4
- One sub-module: slow_prescaler.
  - Owns pre; exposes load (restart at TICK_DIV-1) and a tick pulse when pre==0.
  - Top level keeps the FSM, cnt, hit detection and output registers.

Test Plan:
- TICK_DIV=4, SlowVIA=1, SlowTimeout=3; 4-cycle bus cycle with SelVIA=1 -> Slow rises the cycle after the BACT rising edge and stays high exactly 12 cycles, then falls; ClockGate stays 0 with SlowClockGate=0.
- SlowTimeout=0, SlowSCC=1; 6-cycle BACT with SelSCC=1 -> Slow high for the 6 cycles following the hit cycle; falls the cycle after BACT drops.
- SlowTimeout=2 with an 20-cycle BACT -> expiry at 8 cycles enters HOLD; Slow stays high until BACT falls.
- Retrigger: SlowTimeout=3; second enabled hit at cycle 10 of the first slow period -> Slow continuous, ends 12 cycles after the second hit. Also check a hit coinciding with the expiry edge reloads.
- Disabled or unselected: SelSCSI=1 with SlowSCSI=0, plus SelIWM=1 with BACT already high (no rising edge) -> Slow stays 0.
- POR asserted mid-SLOW with SlowClockGate=1 -> Slow and ClockGate drop without a clock edge. After release, no slow until a new hit occurs.
